// File: rtl/rf_param.sv
// rf_param: DATA_W x 2**ADDR_W register file, two async reads, one sync write.
// Reset/clr run a one-entry-per-cycle clear engine; define RF_BYPASS_EN for write-first reads.
module rf_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nx;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              wr_ok;

    // A user write that will land in storage (ignoring rst, which only blocks the edge)
    assign wr_ok = (state == READY) && !clr && WE3
                   && !((ZERO_REG != 0) && (A3 == '0));

    // State register and clear index; rst restarts the engine from entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state logic and selection of the single storage write per cycle
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        mem_we   = 1'b0;
        mem_wa   = A3;
        mem_wd   = WD3;
        unique case (state)
            CLEAR: begin
                if (clr) begin
                    idx_nx = '0;
                end else begin
                    mem_we = !rst;
                    mem_wa = idx;
                    mem_wd = '0;
                    if (idx == LAST) begin
                        state_nx = READY;
                    end else begin
                        idx_nx = idx + ADDR_W'(1);
                    end
                end
            end
            READY: begin
                if (clr) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                end else begin
                    mem_we = wr_ok && !rst;
                end
            end
            default: begin
                state_nx = CLEAR;
                idx_nx   = '0;
            end
        endcase
    end

    // Storage has no reset so it can map onto plain RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        if (state != READY) begin
            rd = '0;
        end else if ((ZERO_REG != 0) && (a == '0)) begin
            rd = '0;
`ifdef RF_BYPASS_EN
        end else if (wr_ok && (A3 == a)) begin
            rd = WD3;
`endif
        end else begin
            rd = mem[a];
        end
    endfunction

    // Outputs: busy straight from state, reads gated until the clear completes
    always_comb begin
        busy = (state == CLEAR);
        RD1  = rd(A1);
        RD2  = rd(A2);
    end

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: table vectors, hand-written clear/bypass sequences and random
// traffic against a behavioural model, for ZERO_REG=1 and ZERO_REG=0 instances.
module tb_rf_param;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  a1 = '0;
    logic [4:0]  a2 = '0;
    logic        we3 = 1'b0;
    logic [4:0]  a3 = '0;
    logic [31:0] wd3 = '0;
    logic [31:0] rd1z, rd2z, rd1n, rd2n;
    logic        busyz, busyn;

    int vectors = 0;
    int mis = 0;

    always #5 clk = ~clk;

    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .A1(a1), .A2(a2), .RD1(rd1z), .RD2(rd2z),
        .WE3(we3), .A3(a3), .WD3(wd3), .busy(busyz)
    );

    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr),
        .A1(a1), .A2(a2), .RD1(rd1n), .RD2(rd2n),
        .WE3(we3), .A3(a3), .WD3(wd3), .busy(busyn)
    );

    // Behavioural model: a busy flag, a clear pointer and two arrays
    logic        m_busy = 1'b1;
    int          m_idx = 0;
    logic [31:0] mz [DEPTH];
    logic [31:0] mn [DEPTH];

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end else if (m_busy) begin
            if (clr) begin
                m_idx = 0;
            end else begin
                mz[m_idx] = '0;
                mn[m_idx] = '0;
                if (m_idx == DEPTH - 1) m_busy = 1'b0;
                else m_idx = m_idx + 1;
            end
        end else if (clr) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end else if (we3) begin
            mn[a3] = wd3;
            if (a3 != 0) mz[a3] = wd3;
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
        if (m_busy) return '0;
        if (zr && a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (we3 && !clr && a3 == a && !(zr && a3 == 0)) return wd3;
`endif
        return zr ? mz[a] : mn[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("busy_z", {31'b0, busyz}, {31'b0, m_busy});
        chk("busy_n", {31'b0, busyn}, {31'b0, m_busy});
        chk("rd1_z", rd1z, exp_rd(1'b1, a1));
        chk("rd2_z", rd2z, exp_rd(1'b1, a2));
        chk("rd1_n", rd1n, exp_rd(1'b0, a1));
        chk("rd2_n", rd2n, exp_rd(1'b0, a2));
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        advance();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    // Counts cycles with busy high, bounded, then compares with the expected length
    task automatic measure_busy(input string name, input int exp);
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check_model();
            if (!busyz) begin
                done = 1;
                break;
            end
            n++;
            advance();
        end
        if (done) advance();
        chk(name, n, exp);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1z;
        logic [31:0] e1n;
        logic [31:0] e2z;
        logic [31:0] e2n;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 5'd0, 32'h12345678, 5'd5, 5'd5,
                   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd5,
                   0, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 5'd4, 32'h11, 5'd0, 5'd3, 0, 32'h12345678, 0, 0};
        tbl[4] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 32'h11, 32'h11, 32'h11, 32'h11};

        for (int i = 0; i < DEPTH; i++) begin
            mz[i] = '0;
            mn[i] = '0;
        end

        // Reset clear: 32 busy cycles, reads zero throughout and afterwards
        #2;
        pulse_rst();
        measure_busy("rst_busy_len", 32);
        for (int i = 0; i < DEPTH; i += 2) begin
            a1 = 5'(i);
            a2 = 5'(i + 1);
            @(negedge clk);
            chk("cleared_rd1_n", rd1n, 32'h0);
            chk("cleared_rd2_n", rd2n, 32'h0);
            check_model();
            advance();
        end

        // Table vectors in READY
        for (int i = 0; i < 5; i++) begin
            we3 = tbl[i].we;
            a3  = tbl[i].a3;
            wd3 = tbl[i].wd;
            a1  = tbl[i].a1;
            a2  = tbl[i].a2;
            @(negedge clk);
            chk("tbl_rd1_z", rd1z, tbl[i].e1z);
            chk("tbl_rd1_n", rd1n, tbl[i].e1n);
            chk("tbl_rd2_z", rd2z, tbl[i].e2z);
            chk("tbl_rd2_n", rd2n, tbl[i].e2n);
            check_model();
            advance();
        end

        // Read-during-write: entry 4 holds 0x11, write 0x77
        we3 = 1'b1; a3 = 5'd4; wd3 = 32'h77; a1 = 5'd4; a2 = 5'd4;
        @(negedge clk);
`ifdef RF_BYPASS_EN
        chk("rdw_same_cycle", rd1z, 32'h77);
`else
        chk("rdw_same_cycle", rd1z, 32'h11);
`endif
        check_model();
        advance();
        we3 = 1'b0;
        @(negedge clk);
        chk("rdw_next_cycle", rd1z, 32'h77);
        check_model();
        advance();

        // Write dropped in cycle 3 of the clear
        pulse_rst();
        step();
        step();
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'hAA;
        step();
        we3 = 1'b0;
        measure_busy("drop_busy_len", 29);
        a1 = 5'd7;
        @(negedge clk);
        chk("drop_rd_7", rd1z, 32'h0);
        check_model();
        advance();

        // Soft clear with coincident write, then a restart at idx 10
        for (int i = 1; i < DEPTH; i++) begin
            we3 = 1'b1; a3 = 5'(i); wd3 = i;
            step();
        end
        a1 = 5'd9; a2 = 5'd31; we3 = 1'b0;
        @(negedge clk);
        chk("fill_rd_9", rd1z, 32'd9);
        chk("fill_rd_31", rd2z, 32'd31);
        advance();
        clr = 1'b1; we3 = 1'b1; a3 = 5'd9; wd3 = 32'h55;
        advance();
        clr = 1'b0; we3 = 1'b0;
        measure_busy("clr_busy_len", 32);
        @(negedge clk);
        chk("clr_rd_9", rd1z, 32'h0);
        check_model();
        advance();
        clr = 1'b1;
        advance();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        measure_busy("restart_busy_len", 32);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 49) == 0);
            we3 = 1'($urandom_range(0, 1));
            a3  = 5'($urandom_range(0, 31));
            wd3 = $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0; clr = 1'b0; we3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, mis);
        $finish;
    end

endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised successor of the CPU register file: DATA_W-bit words, 2**ADDR_W entries, two combinational read ports, one synchronous write port.
- Optional hard-wired zero register.
- Reset and soft clear run as a sequential clear engine, one entry per cycle, so storage maps to plain block/distributed RAM instead of a full-width reset.
- Sits between decode (read addresses) and writeback (write port) in the core datapath.

Parameters:
DATA_W, 32, word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  soft clear request, sampled on rising edge
A1  in  ADDR_W  read address, port 1
A2  in  ADDR_W  read address, port 2
RD1  out  DATA_W  read data, port 1 (combinational)
RD2  out  DATA_W  read data, port 2 (combinational)
WE3  in  1  write enable
A3  in  ADDR_W  write address
WD3  in  DATA_W  write data
busy  out  1  high while the clear engine runs

Behaviour:
- State machine: CLEAR, READY.
- rst high at an edge:
  - state <= CLEAR, clear index idx <= 0.
  - No storage write that cycle.
  - Overrides clr and WE3.
  - Legal mid-clear; restarts from idx 0.
- CLEAR, each edge without rst:
  - mem[idx] <= 0.
  - If idx == DEPTH-1: state <= READY. Otherwise idx <= idx+1.
  - Full clear takes exactly DEPTH cycles after rst deasserts.
- CLEAR ignores WE3; the write is dropped, not queued.
- clr high during CLEAR: idx <= 0, restart. No entry is written at idx that edge.
- READY, clr high: state <= CLEAR, idx <= 0. A coincident WE3 is dropped.
- READY, clr low, WE3 high:
  - mem[A3] <= WD3 at the edge.
  - Suppressed when ZERO_REG=1 and A3==0.
- busy = (state == CLEAR), purely from the state register.
  - 1 from the edge that samples rst until the edge that completes entry DEPTH-1.
  - Reset value 1.
- Reads:
  - RDn = 0 while busy.
  - RDn = 0 if ZERO_REG=1 and An==0.
  - Otherwise RDn = mem[An].
  - Reset value of RD1/RD2 is 0 (busy).
- A1==A2: both ports return the same value.
- Read-during-write to the same address without bypass: the old value is visible until the edge, the new value after.
- Pre-reset storage contents are undefined. busy must gate reads until the first clear completes.
- No wrap-around beyond DEPTH-1. idx is ADDR_W bits wide and stops at DEPTH-1.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: in READY, if WE3=1, clr=0, A3==An, and the write is not suppressed by ZERO_REG, then RDn = WD3 combinationally in the same cycle (write-first forwarding). Still 0 while busy.
- Undefined: no forwarding. RDn shows stored content (read-first); the new value is visible from the next cycle.
- Storage update timing is identical in both builds.

Test Plan:
- Reset clear: rst high 1 cycle, default params.
  - busy=1 for exactly 32 cycles after rst deasserts, then 0.
  - RD1/RD2=0 throughout.
  - All 32 entries read 0 afterwards.
- Basic write/read, READY:
  - WE3=1, A3=5, WD3=0xDEADBEEF.
  - Next cycle A1=5 gives RD1=0xDEADBEEF.
  - A2=5 gives the same value on RD2.
- Zero register:
  - ZERO_REG=1: write A3=0, WD3=0x12345678; then A1=0 reads 0.
  - ZERO_REG=0: same stimulus reads 0x12345678.
- Dropped write during clear:
  - WE3=1, A3=7, WD3=0xAA in cycle 3 of CLEAR.
  - After busy falls, RD1 at A1=7 is 0.
- Soft clear mid-operation:
  - Fill entries 1..31 with index values. Assert clr in READY with coincident WE3 to A3=9, WD3=0x55.
  - busy=1 for 32 cycles; entry 9 reads 0 afterward.
  - Assert clr again at idx=10: busy lasts 32 more cycles from the restart.
- Read-during-write: A1=A3=4, WD3=0x77, old value 0x11.
  - Same cycle RD1=0x77 with RF_BYPASS_EN, 0x11 without.
  - Next cycle 0x77 in both builds.
